// File: rtl/ram_port_arbiter.sv
// Two-master (fetch M0, load/store M1) round-robin arbiter in front of the board RAM controller.
// Optional slave timeout is compiled in with `define RAM_ARBITER_TIMEOUT_EN.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH     = 25,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_stb_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  output logic [31:0]           m0_data_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_sel_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [31:0]           m1_data_i,
  output logic [31:0]           m1_data_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [3:0]            s_sel_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [31:0]           s_data_o,
  input  logic [31:0]           s_data_i,
  input  logic                  s_ack_i
);

  typedef enum logic [1:0] {IDLE, GRANT_M0, GRANT_M1} state_t;

  typedef struct packed {
    logic                  we;
    logic [3:0]            sel;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           data;
  } s_req_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;       // 1: M1 was granted last
  logic          stb_q, stb_d;
  s_req_t        req_q, req_d;
  logic [31:0]   m0_dat_q, m0_dat_d, m1_dat_q, m1_dat_d;
  logic          m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic          m0_elig, m1_elig, pick_m1, tout;

`ifdef RAM_ARBITER_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  assign m0_err_o = m0_err_q;
  assign m1_err_o = m1_err_q;
`else
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

  // a master finishing this cycle is still holding stb; don't grant it again
  assign m0_elig = m0_stb_i & ~m0_ack_q & ~m0_err_o;
  assign m1_elig = m1_stb_i & ~m1_ack_q & ~m1_err_o;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    stb_d    = stb_q;
    req_d    = req_q;
    m0_dat_d = m0_dat_q;
    m1_dat_d = m1_dat_q;
    m0_ack_d = 1'b0;
    m1_ack_d = 1'b0;
    pick_m1  = 1'b0;
    tout     = 1'b0;
`ifdef RAM_ARBITER_TIMEOUT_EN
    cnt_d    = cnt_q;
    m0_err_d = 1'b0;
    m1_err_d = 1'b0;
    tout     = (cnt_q == CNT_MAX);
`endif
    case (state_q)
      IDLE: begin
        if (m0_elig || m1_elig) begin
          pick_m1 = m1_elig & (~m0_elig | ~last_q);
          if (pick_m1) begin
            req_d.we   = m1_we_i;
            req_d.sel  = m1_sel_i;
            req_d.addr = m1_addr_i;
            req_d.data = m1_data_i;
          end else begin
            req_d.we   = 1'b0;
            req_d.sel  = 4'hF;
            req_d.addr = m0_addr_i;
            req_d.data = 32'h0;
          end
          stb_d   = 1'b1;
          last_d  = pick_m1;
          state_d = pick_m1 ? GRANT_M1 : GRANT_M0;
`ifdef RAM_ARBITER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT_M0, GRANT_M1: begin
        if (s_ack_i) begin
          stb_d   = 1'b0;
          state_d = IDLE;
          if (state_q == GRANT_M1) begin
            m1_ack_d = 1'b1;
            m1_dat_d = s_data_i;
          end else begin
            m0_ack_d = 1'b1;
            m0_dat_d = s_data_i;
          end
        end else if (tout) begin
          stb_d   = 1'b0;
          state_d = IDLE;
`ifdef RAM_ARBITER_TIMEOUT_EN
          m1_err_d = (state_q == GRANT_M1);
          m0_err_d = (state_q == GRANT_M0);
`endif
        end else begin
`ifdef RAM_ARBITER_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        stb_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      stb_q    <= 1'b0;
      req_q    <= '0;
      m0_dat_q <= '0;
      m1_dat_q <= '0;
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
`ifdef RAM_ARBITER_TIMEOUT_EN
      cnt_q    <= '0;
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      stb_q    <= stb_d;
      req_q    <= req_d;
      m0_dat_q <= m0_dat_d;
      m1_dat_q <= m1_dat_d;
      m0_ack_q <= m0_ack_d;
      m1_ack_q <= m1_ack_d;
`ifdef RAM_ARBITER_TIMEOUT_EN
      cnt_q    <= cnt_d;
      m0_err_q <= m0_err_d;
      m1_err_q <= m1_err_d;
`endif
    end
  end

  assign s_stb_o   = stb_q;
  assign s_we_o    = req_q.we;
  assign s_sel_o   = req_q.sel;
  assign s_addr_o  = req_q.addr;
  assign s_data_o  = req_q.data;
  assign m0_data_o = m0_dat_q;
  assign m1_data_o = m1_dat_q;
  assign m0_ack_o  = m0_ack_q;
  assign m1_ack_o  = m1_ack_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_ram_port_arbiter;
  localparam int AW = 25;
  localparam int T  = 8;
`ifdef RAM_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk_i = 1'b0, rst_i = 1'b1;
  logic          m0_stb_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
  logic [AW-1:0] m0_addr_i = '0, m1_addr_i = '0, s_addr_o;
  logic [3:0]    m1_sel_i = '0, s_sel_o;
  logic [31:0]   m1_data_i = '0, s_data_i = '0, m0_data_o, m1_data_o, s_data_o;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_stb_o, s_we_o;
  logic          s_ack_i = 1'b0;

  always #5 clk_i = ~clk_i;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_stb_i(m0_stb_i), .m0_addr_i(m0_addr_i), .m0_data_o(m0_data_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_addr_o(s_addr_o),
    .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i)
  );

  int total = 0, bad = 0;

  // model state, updated once per cycle at the falling edge
  bit          prev_rst = 1'b1, prev_sstb = 1'b0, prev_ack_due = 1'b0, prev_to_due = 1'b0;
  bit          last_m = 1'b1;
  int          cur_m = 0, n_hi = 0;
  bit [1:0]    prev_elig = '0;
  logic [31:0] prev_sdata = '0;
  logic [31:0] dat_exp [2];
  int          glog [$];

  // master agents
  bit          stb [2];
  logic        we [2];
  logic [3:0]  sel [2];
  logic [AW-1:0] addr [2];
  logic [31:0] wdat [2];
  int          budget [2];
  int          prob = 100;
  bit          fix [2];
  logic        fwe [2];
  logic [3:0]  fsel [2];
  logic [AW-1:0] faddr [2];
  logic [31:0] fdat [2];
  int          issued [2], acked [2], errs [2];

  // slave agent
  bit          s_never = 1'b0, s_fix = 1'b0, s_rand_dly = 1'b1, spur = 1'b0, force_ack = 1'b0;
  bit          s_acked = 1'b0;
  int          s_dly = 0, scnt = 0;
  logic [31:0] s_fixdat = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic clr();
    glog.delete();
    for (int m = 0; m < 2; m++) begin
      issued[m] = 0; acked[m] = 0; errs[m] = 0; fix[m] = 1'b0; budget[m] = 0;
    end
  endtask

  task automatic step(input bit r);
    bit       exp_stb, sack;
    bit [1:0] elig;
    int       em;
    @(negedge clk_i);
    if (prev_rst) begin
      chk("rst_ctl", {s_stb_o, s_we_o, s_sel_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 64'h0);
      chk("rst_bus", {s_addr_o, s_data_o}, 64'h0);
      chk("rst_mdat", {m0_data_o, m1_data_o}, 64'h0);
      dat_exp[0] = '0; dat_exp[1] = '0;
    end else begin
      exp_stb = prev_sstb ? !(prev_ack_due || prev_to_due) : (prev_elig != 2'b00);
      chk("s_stb", s_stb_o, exp_stb);
      chk("m0_ack", m0_ack_o, prev_ack_due && cur_m == 0);
      chk("m1_ack", m1_ack_o, prev_ack_due && cur_m == 1);
      chk("m0_err", m0_err_o, prev_to_due && cur_m == 0);
      chk("m1_err", m1_err_o, prev_to_due && cur_m == 1);
      if (prev_ack_due) dat_exp[cur_m] = prev_sdata;
      chk("m0_data", m0_data_o, dat_exp[0]);
      chk("m1_data", m1_data_o, dat_exp[1]);
      if (s_stb_o && !prev_sstb) begin
        em = (prev_elig == 2'b11) ? int'(!last_m) : int'(prev_elig[1]);
        cur_m = em; last_m = em[0]; glog.push_back(em); n_hi = 0;
        chk("s_addr", s_addr_o, addr[em]);
        chk("s_we", s_we_o, (em == 1) ? we[1] : 1'b0);
        chk("s_sel", s_sel_o, (em == 1) ? sel[1] : 4'hF);
        if (em == 1) chk("s_wdat", s_data_o, wdat[1]);
      end
    end
    if (m0_ack_o) acked[0]++;
    if (m1_ack_o) acked[1]++;
    if (m0_err_o) errs[0]++;
    if (m1_err_o) errs[1]++;
    if (s_stb_o) n_hi++;

    sack = 1'b0;
    if (s_stb_o) begin
      if (!s_acked && !s_never) begin
        if (scnt == 0) begin sack = 1'b1; s_acked = 1'b1; end
        else scnt--;
      end
    end else begin
      s_acked = 1'b0;
      scnt = s_rand_dly ? int'($urandom_range(3, 0)) : s_dly;
      sack = force_ack || (spur && $urandom_range(7, 0) == 0);
    end
    force_ack = 1'b0;
    s_ack_i  = sack;
    s_data_i = s_fix ? s_fixdat : $urandom;

    for (int m = 0; m < 2; m++) begin
      if ((m == 0) ? (m0_ack_o || m0_err_o) : (m1_ack_o || m1_err_o)) stb[m] = 1'b0;
      if (r) begin
        stb[m] = 1'b0; budget[m] = 0;
      end else if (!stb[m] && budget[m] > 0 && $urandom_range(99, 0) < prob) begin
        stb[m] = 1'b1; budget[m]--; issued[m]++;
        if (fix[m]) begin
          addr[m] = faddr[m]; we[m] = fwe[m]; sel[m] = fsel[m]; wdat[m] = fdat[m];
        end else begin
          addr[m] = AW'($urandom); we[m] = (m == 1) ? 1'($urandom) : 1'b0;
          sel[m] = (m == 1) ? 4'($urandom) : 4'hF; wdat[m] = $urandom;
        end
      end
    end
    m0_stb_i = stb[0]; m0_addr_i = addr[0];
    m1_stb_i = stb[1]; m1_addr_i = addr[1]; m1_we_i = we[1]; m1_sel_i = sel[1]; m1_data_i = wdat[1];
    rst_i = r;

    elig = {stb[1] && !m1_ack_o && !m1_err_o, stb[0] && !m0_ack_o && !m0_err_o};
    prev_elig    = r ? 2'b00 : elig;
    prev_ack_due = !r && s_stb_o && sack;
    prev_to_due  = !r && TO_EN && s_stb_o && !sack && n_hi == T;
    prev_sstb    = r ? 1'b0 : s_stb_o;
    prev_sdata   = s_data_i;
    prev_rst     = r;
    if (r) begin last_m = 1'b1; n_hi = 0; s_acked = 1'b0; end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      stb[m] = 1'b0; we[m] = 1'b0; sel[m] = 4'hF; addr[m] = '0; wdat[m] = '0; dat_exp[m] = '0;
      fwe[m] = 1'b0; fsel[m] = 4'hF; faddr[m] = '0; fdat[m] = '0;
    end
    clr();
    repeat (3) step(1'b1);

    // single M0 read, slave acks 3 cycles after s_stb rises
    fix[0] = 1'b1; faddr[0] = 25'h0000100;
    s_rand_dly = 1'b0; s_dly = 2; s_fix = 1'b1; s_fixdat = 32'hDEADBEEF;
    budget[0] = 1;
    repeat (12) step(1'b0);
    chk("t1_acks", acked[0], 1);
    chk("t1_data", m0_data_o, 32'hDEADBEEF);
    chk("t1_grants", glog.size(), 1);

    // simultaneous requests straight after reset
    repeat (2) step(1'b1);
    clr(); s_fix = 1'b0;
    fix[1] = 1'b1; fwe[1] = 1'b1; fsel[1] = 4'h3; faddr[1] = 25'h40; fdat[1] = 32'h12345678;
    budget[0] = 1; budget[1] = 1;
    repeat (20) step(1'b0);
    chk("t2_grants", glog.size(), 2);
    chk("t2_first", glog[0], 0);
    chk("t2_second", glog[1], 1);
    chk("t2_m1_ack", acked[1], 1);

    // continuous contention: strict alternation
    repeat (2) step(1'b1);
    clr(); s_rand_dly = 1'b1;
    budget[0] = 3; budget[1] = 3;
    repeat (60) step(1'b0);
    chk("t3_grants", glog.size(), 6);
    for (int i = 0; i < 6; i++) chk("t3_order", glog[i], i % 2);
    chk("t3_acks", acked[0] + acked[1], 6);

    // reset while M1 is granted; a late slave ack must be ignored
    repeat (2) step(1'b1);
    clr(); s_never = 1'b1; budget[1] = 1;
    repeat (4) step(1'b0);
    chk("t4_busy", s_stb_o, 1'b1);
    chk("t4_owner", glog[0], 1);
    step(1'b1);
    step(1'b0);
    s_never = 1'b0; force_ack = 1'b1;
    repeat (4) step(1'b0);
    chk("t4_noack", acked[1], 0);

    // slave never answers an M1 read
    repeat (2) step(1'b1);
    clr(); s_never = 1'b1;
    fix[1] = 1'b1; fwe[1] = 1'b0; fsel[1] = 4'hF; faddr[1] = 25'h1234; fdat[1] = 32'h0;
    budget[1] = 1;
`ifdef RAM_ARBITER_TIMEOUT_EN
    repeat (16) step(1'b0);
    chk("t5_err", errs[1], 1);
    chk("t5_stb", s_stb_o, 1'b0);
    s_never = 1'b0; budget[0] = 1;
    repeat (10) step(1'b0);
    chk("t5_m0", acked[0], 1);
`else
    repeat (2000) step(1'b0);
    chk("t6_stb", s_stb_o, 1'b1);
    chk("t6_err", errs[1], 0);
    s_never = 1'b0;
`endif

    // random traffic with spurious slave acks between transactions
    repeat (2) step(1'b1);
    clr(); spur = 1'b1; prob = 50;
    budget[0] = 300; budget[1] = 300;
    repeat (3000) step(1'b0);
    budget[0] = 0; budget[1] = 0; spur = 1'b0;
    repeat (20) step(1'b0);
    chk("rnd_m0_done", acked[0], issued[0]);
    chk("rnd_m1_done", acked[1], issued[1]);
    chk("rnd_errs", errs[0] + errs[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single RAM controller slave port (sdram/psram controller) between the instruction-fetch master (M0, read-only) and the load/store master (M1).
- Sits inside mem_space, between the pipeline fetch/memory stages and the board RAM controller.
- One transaction in flight at a time.
- Round-robin on contention.
- Registered response path.

Parameters:
- ADDR_WIDTH, 25, byte-address width forwarded to the RAM controller.
- TIMEOUT_CYCLES, 1024, cycles a granted transaction may wait for s_ack_i before an error is returned. Used only with the optional feature.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous, active-high reset
- m0_stb_i  input  1  fetch request; held until m0_ack_o or m0_err_o
- m0_addr_i  input  ADDR_WIDTH  fetch address
- m0_data_o  output  32  fetch read data, valid with m0_ack_o
- m0_ack_o  output  1  fetch completion, 1-cycle pulse
- m0_err_o  output  1  fetch timeout, 1-cycle pulse
- m1_stb_i  input  1  data request; held until m1_ack_o or m1_err_o
- m1_we_i  input  1  1 = write
- m1_sel_i  input  4  byte enables
- m1_addr_i  input  ADDR_WIDTH  data address
- m1_data_i  input  32  write data
- m1_data_o  output  32  read data, valid with m1_ack_o
- m1_ack_o  output  1  data completion, 1-cycle pulse
- m1_err_o  output  1  data timeout, 1-cycle pulse
- s_stb_o  output  1  request to RAM controller
- s_we_o  output  1  write enable to controller
- s_sel_o  output  4  byte enables to controller
- s_addr_o  output  ADDR_WIDTH  address to controller
- s_data_o  output  32  write data to controller
- s_data_i  input  32  read data from controller
- s_ack_i  input  1  controller completion

Behaviour:
- Reset (rst_i high on a clk_i edge, including mid-transaction):
  - state = IDLE; last_grant = M1, so M0 wins the first tie.
  - All outputs 0.
  - Any in-flight slave transaction is abandoned; an s_ack_i arriving later in IDLE is ignored.
- States: IDLE, GRANT_M0, GRANT_M1.
- IDLE:
  - A master is eligible if its stb_i = 1 and its ack_o/err_o is not asserted in that cycle. This prevents re-granting a request being dropped.
  - Single eligible master: grant it.
  - Both eligible: grant the master that is not last_grant.
  - On grant: latch addr/we/sel/data into the s_* registers, set s_stb_o = 1 next cycle, update last_grant, go to GRANT_x.
  - M0 grant forces s_we_o = 0 and s_sel_o = 4'hF.
- GRANT_x:
  - s_* outputs held stable.
  - Master inputs are not re-sampled; masters must hold their request stable.
  - On s_ack_i = 1: next cycle s_stb_o = 0, mx_ack_o = 1 for exactly one cycle, mx_data_o = s_data_i captured at the ack edge, state -> IDLE.
  - mx_data_o holds its value until the next ack to that master.
  - Writes also capture s_data_i; contents are don't-care.
- Latency:
  - Request sampled in IDLE at edge N -> s_stb_o high from N+1.
  - s_ack_i at edge N+k -> mx_ack_o high during N+k+1.
  - The next grant can be sampled at edge N+k+1, giving s_stb_o at N+k+2. Minimum one idle cycle between slave transactions.
- s_ack_i while s_stb_o = 0: ignored.
- Wishbone-classic rule: a master drops stb_i in the cycle it sees ack_o.
- Starvation bound: with both masters continuously requesting, grants strictly alternate M0, M1, M0, …

Optional Feature:
- Macro: RAM_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter clears on entering GRANT_x and increments each cycle without s_ack_i.
  - When the count reaches TIMEOUT_CYCLES - 1 without ack: next cycle s_stb_o = 0, mx_err_o = 1 for one cycle, mx_ack_o = 0, mx_data_o unchanged, state -> IDLE.
  - s_ack_i on the same edge the count reaches TIMEOUT_CYCLES - 1 wins: normal ack, no error.
- Undefined:
  - No counter; the arbiter waits indefinitely.
  - m0_err_o and m1_err_o are tied 0.

Test Plan:
- Reset, then M0 read 0x0000100 with slave ack 3 cycles after s_stb_o, s_data_i = 0xDEADBEEF -> s_stb_o rises 1 cycle after request; m0_ack_o pulses 1 cycle after s_ack_i; m0_data_o = 0xDEADBEEF; s_we_o = 0, s_sel_o = F.
- M0 and M1 (write 0x12345678, sel 0x3, addr 0x40) asserted same cycle after reset -> M0 granted first, then M1 with s_we_o = 1, s_sel_o = 3, s_data_o = 0x12345678; exactly one idle cycle between s_stb_o pulses.
- Both masters re-request continuously for 6 transactions -> grant order M0, M1, M0, M1, M0, M1; no transaction lost or duplicated.
- rst_i asserted while GRANT_M1 with s_stb_o high, slave acks 2 cycles later -> all outputs 0 the cycle after reset; late s_ack_i produces no m1_ack_o.
- With RAM_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES = 8, slave never acks M1 read -> m1_err_o pulses once; s_stb_o low from the same cycle; next M0 request is granted normally.
- Without RAM_ARBITER_TIMEOUT_EN, same stimulus for 2000 cycles -> s_stb_o stays high and m1_err_o stays 0.
